// File: rtl/decompress.sv
// Kyber decompressor: unpacks d-bit fields from 32-bit words and
// maps each to round(3329*x / 2^d), eight 12-bit coefficients per beat.
module decompress (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  d,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [95:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t         state, state_n;
   logic [3:0]     d_r;
   logic [6:0]     words;
   logic [4:0]     groups;
   logic [111:0]   bbuf, bbuf_n;
   logic [6:0]     fill, fill_n, fill_base;
   logic [6:0]     gw;
   logic           s1_valid;
   logic [79:0]    s1_data, fields;
   logic [95:0]    s2_n;
   logic [21:0]    rnd, prod, coef;
   logic           legal, go, accept, xfer, s2_free, s1_move, extract;

   assign legal   = (d == 4'd1) || (d == 4'd4) || (d == 4'd10);
   assign go      = (state == IDLE) && start && legal;
   assign accept  = in_valid && in_ready;
   assign xfer    = out_valid && out_ready;
   assign s2_free = !out_valid || out_ready;
   assign s1_move = s1_valid && s2_free;
   assign extract = (state != IDLE) && (fill >= gw)
                    && (!s1_valid || s1_move);

   // Group width in bits equals the word count of a polynomial (8*d).
   always_comb begin
      gw  = 7'd8;
      rnd = 22'd1;
      case (d_r)
         4'd4:    begin gw = 7'd32; rnd = 22'd8;   end
         4'd10:   begin gw = 7'd80; rnd = 22'd512; end
         default: begin gw = 7'd8;  rnd = 22'd1;   end
      endcase
   end

   assign in_ready = (state == RUN) && (fill <= 7'd80) && (words < gw);
   assign out_last = out_valid && (groups == 5'd31);
   assign done     = (state == FLUSH) && xfer && out_last;

   // Gearbox: drop the extracted group, then append above what remains.
   always_comb begin
      fill_base = extract ? (fill - gw) : fill;
      bbuf_n    = extract ? (bbuf >> gw) : bbuf;
      if (accept)
         bbuf_n = bbuf_n | ({80'd0, in_data} << fill_base);
      fill_n = fill_base + (accept ? 7'd32 : 7'd0);
   end

   always_comb begin
      fields = '0;
      for (int i = 0; i < 8; i++) begin
         case (d_r)
            4'd1:    fields[10*i +: 10] = {9'd0, bbuf[i]};
            4'd4:    fields[10*i +: 10] = {6'd0, bbuf[4*i +: 4]};
            4'd10:   fields[10*i +: 10] = bbuf[10*i +: 10];
            default: fields[10*i +: 10] = 10'd0;
         endcase
      end
   end

   always_comb begin
      s2_n = '0;
      prod = '0;
      coef = '0;
      for (int i = 0; i < 8; i++) begin
         prod = {12'd0, s1_data[10*i +: 10]} * 22'd3329 + rnd;
         coef = prod >> d_r;
         s2_n[12*i +: 12] = coef[11:0];
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (go) state_n = RUN;
         RUN:     if (accept && (words == gw - 7'd1)) state_n = FLUSH;
         FLUSH:   if (done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         d_r       <= '0;
         words     <= '0;
         groups    <= '0;
         bbuf      <= '0;
         fill      <= '0;
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err       <= 1'b0;
      end else begin
         state <= state_n;
         err   <= (state == IDLE) && start && !legal;
         if (go) begin
            d_r    <= d;
            words  <= '0;
            groups <= '0;
            bbuf   <= '0;
            fill   <= '0;
         end else begin
            if (accept) words <= words + 7'd1;
            if (xfer) groups <= groups + 5'd1;
            bbuf <= bbuf_n;
            fill <= fill_n;
         end
         if (extract) begin
            s1_valid <= 1'b1;
            s1_data  <= fields;
         end else if (s1_move) begin
            s1_valid <= 1'b0;
         end
         if (s1_move) begin
            out_valid <= 1'b1;
            out_data  <= s2_n;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decompress.sv
// Randomised bench for decompress against a bit-level reference model.
module tb_decompress;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, out_ready;
   logic [3:0]  d;
   logic [31:0] in_data;
   logic        in_ready, out_valid, out_last, done, err;
   logic [95:0] out_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] wv [80];
   logic [95:0] expq [32];
   logic [95:0] got0;

   decompress dut (
      .clk(clk), .rst(rst), .start(start), .d(d),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] got,
                        input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Stream is LSB-first; coefficient j occupies bits d*j .. d*j+d-1.
   function automatic void build(input int dd);
      for (int j = 0; j < 256; j++) begin
         int x = 0;
         int c;
         for (int b = 0; b < dd; b++) begin
            int p = dd * j + b;
            if (wv[p / 32][p % 32]) x += (1 << b);
         end
         c = (2 * 3329 * x + (1 << dd)) / (1 << (dd + 1));
         expq[j / 8][12 * (j % 8) +: 12] = 12'(c);
      end
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_rdy"}, 96'(in_ready), 96'd0);
      check({tag, "_ov"}, 96'(out_valid), 96'd0);
      check({tag, "_od"}, out_data, 96'd0);
      check({tag, "_ol"}, 96'(out_last), 96'd0);
      check({tag, "_done"}, 96'(done), 96'd0);
      check({tag, "_err"}, 96'(err), 96'd0);
   endtask

   // mode 0: always ready/valid; 1: random; 2: output stall window
   task automatic run_poly(input int dd, input int mode,
                           input int abort_w, input int restart_at);
      int  wi = 0;
      int  bi = 0;
      int  ndone = 0;
      int  cyc = 0;
      logic viol = 1'b0;
      logic drop = 1'b0;
      logic acc, xf;
      build(dd);
      @(negedge clk);
      start = 1'b1;
      d = 4'(dd);
      #1 check("rdy_at_start", 96'(in_ready), 96'd0);
      @(negedge clk);
      start = 1'b0;
      while (ndone == 0 && cyc < 4000) begin
         start = (cyc == restart_at);
         d = start ? 4'd4 : 4'(dd);
         in_valid = (wi < 8 * dd) &&
                    ((mode == 1) ? ($urandom % 4 != 0) : 1'b1);
         in_data = (wi < 80) ? wv[wi] : 32'd0;
         if (mode == 1) out_ready = ($urandom % 3 != 0);
         else if (mode == 2) out_ready = !(cyc >= 15 && cyc < 25);
         else out_ready = 1'b1;
         #1;
         if (wi >= 8 * dd && in_ready) viol = 1'b1;
         if (mode == 2 && !out_ready && !in_ready && wi < 80) drop = 1'b1;
         acc = in_valid && in_ready;
         xf = out_valid && out_ready;
         if (out_valid) begin
            if (bi < 32) begin
               check("beat", out_data, expq[bi]);
               check("last", 96'(out_last), 96'(bi == 31));
            end else begin
               check("extra_beat", 96'(bi), 96'd31);
            end
         end
         check("done", 96'(done), 96'(xf && bi == 31));
         if (xf && bi == 0) got0 = out_data;
         if (xf) bi++;
         if (done) ndone++;
         if (acc) wi++;
         cyc++;
         @(posedge clk);
         if (abort_w > 0 && wi >= abort_w) break;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start = 1'b0;
      if (abort_w > 0) begin
         check("abort_words", 96'(wi), 96'(abort_w));
         return;
      end
      check("timeout", 96'(cyc < 4000), 96'd1);
      check("words", 96'(wi), 96'(8 * dd));
      check("beats", 96'(bi), 96'd32);
      check("rdy_after_last", 96'(viol), 96'd0);
      if (mode == 2) check("bp_rdy_drop", 96'(drop), 96'd1);
      repeat (3) begin
         @(negedge clk);
         #1;
         if (done) ndone++;
         check("idle_rdy", 96'(in_ready), 96'd0);
      end
      check("done_cnt", 96'(ndone), 96'd1);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      d = 4'd0;
      in_valid = 1'b0;
      in_data = 32'd0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1 check_zero("reset");
      rst = 1'b0;

      foreach (wv[i]) wv[i] = 32'd0;
      wv[0] = 32'h0000_00FF;
      run_poly(1, 0, 0, 5);
      check("d1_beat0", got0, {8{12'd1665}});

      foreach (wv[i]) wv[i] = $urandom;
      wv[0] = 32'h7654_3210;
      run_poly(4, 0, 0, -1);
      check("d4_beat0", got0, {12'd1456, 12'd1248, 12'd1040, 12'd832,
                               12'd624, 12'd416, 12'd208, 12'd0});

      foreach (wv[i]) wv[i] = 32'hFFFF_FFFF;
      run_poly(10, 0, 0, -1);
      check("d10_beat0", got0, {8{12'd3326}});

      foreach (wv[i]) wv[i] = $urandom;
      run_poly(10, 2, 0, -1);

      @(negedge clk);
      start = 1'b1;
      d = 4'd5;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("err_hi", 96'(err), 96'd1);
      check("err_rdy", 96'(in_ready), 96'd0);
      @(negedge clk);
      #1;
      check("err_lo", 96'(err), 96'd0);
      check("err_rdy2", 96'(in_ready), 96'd0);

      for (int k = 0; k < 3; k++) begin
         foreach (wv[i]) wv[i] = $urandom;
         run_poly((k == 0) ? 1 : (k == 1) ? 4 : 10, 1, 0, -1);
      end

      foreach (wv[i]) wv[i] = $urandom;
      run_poly(4, 0, 12, -1);
      @(negedge clk);
      rst = 1'b1;
      #1 check_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      foreach (wv[i]) wv[i] = $urandom;
      run_poly(1, 1, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
